// File: rtl/bibp_pkg.sv
// Shared definitions for the bibp instruction issuer: opcodes, FSM states, field helpers.
package bibp_pkg;

  localparam logic [2:0] OP_TOPLA = 3'b000;
  localparam logic [2:0] OP_CIKAR = 3'b001;
  localparam logic [2:0] OP_VE    = 3'b010;
  localparam logic [2:0] OP_VEYA  = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;

  typedef enum logic [2:0] {
    StBosta,
    StGonder,
    StYakala,
    StCikis,
    StBitti
  } durum_e;

  // Field helpers take the word zero-extended to 32 bits plus the operand width UZUNLUK.
  function automatic logic [2:0] op_al(input logic [31:0] w, input int unsigned uz);
    return w[uz +: 3];
  endfunction

  function automatic logic [31:0] v1_al(input logic [31:0] w, input int unsigned uz);
    return (w >> (uz / 2)) & ((32'd1 << (uz / 2)) - 32'd1);
  endfunction

  function automatic logic [31:0] v2_al(input logic [31:0] w, input int unsigned uz);
    return w & ((32'd1 << (uz / 2)) - 32'd1);
  endfunction

  function automatic logic gecersiz_op(input logic [2:0] op);
    return op > OP_XOR;
  endfunction

endpackage

// File: rtl/buyruk_sirala_if.sv
// ALU link (buyruk/sonuc) and result stream (cikis_*) of the instruction issuer.
interface buyruk_sirala_if #(
  parameter int unsigned UZUNLUK  = 8,
  parameter int unsigned DERINLIK = 16
);
  localparam int unsigned AW = $clog2(DERINLIK);

  logic [UZUNLUK+2:0] buyruk;
  logic [UZUNLUK:0]   sonuc;
  logic               cikis_gecerli;
  logic               cikis_hazir;
  logic [UZUNLUK:0]   cikis_sonuc;
  logic [AW-1:0]      cikis_adres;

  // Issuer side: drives the ALU and produces the result stream.
  modport master (
    output buyruk,
    input  sonuc,
    output cikis_gecerli,
    input  cikis_hazir,
    output cikis_sonuc,
    output cikis_adres
  );

  // ALU / consumer side.
  modport slave (
    input  buyruk,
    output sonuc,
    input  cikis_gecerli,
    output cikis_hazir,
    input  cikis_sonuc,
    input  cikis_adres
  );
endinterface

// File: rtl/buyruk_bellek.sv
// Program RAM: one synchronous write port, one asynchronous read port, not reset.
module buyruk_bellek #(
  parameter int unsigned Genislik = 11,
  parameter int unsigned Derinlik = 16,
  localparam int unsigned AdresW  = $clog2(Derinlik)
) (
  input  logic                clk_i,
  input  logic                yaz_en_i,
  input  logic [AdresW-1:0]   yaz_adres_i,
  input  logic [Genislik-1:0] yaz_veri_i,
  input  logic [AdresW-1:0]   oku_adres_i,
  output logic [Genislik-1:0] oku_veri_o
);

  logic [Genislik-1:0] mem_q [Derinlik];

  // Store the loader's word on the write strobe.
  always_ff @(posedge clk_i) begin
    if (yaz_en_i) begin
      mem_q[yaz_adres_i] <= yaz_veri_i;
    end
  end

  assign oku_veri_o = mem_q[oku_adres_i];

endmodule

// File: rtl/buyruk_sirala.sv
// Instruction issuer: runs a stored program through the combinational ALU and streams results.
// Optional feature macro BUYRUK_HATA_SAYAC_EN: skip and count illegal opcodes (hata_sayisi).
module buyruk_sirala
  import bibp_pkg::*;
#(
  parameter int unsigned UZUNLUK     = 8,
  parameter int unsigned DERINLIK    = 16,
  parameter int unsigned ALU_GECIKME = 1,
  localparam int unsigned AW         = $clog2(DERINLIK)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               yaz_en,
  input  logic [AW-1:0]      yaz_adres,
  input  logic [UZUNLUK+2:0] yaz_veri,
  input  logic               basla,
  input  logic [AW:0]        program_boyu,
  buyruk_sirala_if.master    bus,
  output logic               mesgul,
`ifdef BUYRUK_HATA_SAYAC_EN
  output logic [AW:0]        hata_sayisi,
`endif
  output logic               bitti
);

  localparam int unsigned W  = UZUNLUK + 3;
  localparam int unsigned RW = UZUNLUK + 1;
  localparam int unsigned CW = (ALU_GECIKME > 1) ? $clog2(ALU_GECIKME) : 1;
  localparam logic [CW-1:0] BekleSon = CW'(ALU_GECIKME - 1);
  localparam logic [AW:0]   Derinlik = (AW + 1)'(DERINLIK);

  durum_e          durum_q, durum_d;
  logic [AW:0]     pc_q, pc_d;
  logic [AW:0]     n_q, n_d;
  logic [CW-1:0]   bekle_q, bekle_d;
  logic [W-1:0]    buyruk_q, buyruk_d;
  logic [RW-1:0]   cikis_sonuc_q, cikis_sonuc_d;
  logic [AW-1:0]   cikis_adres_q, cikis_adres_d;
  logic            cikis_gecerli_q, cikis_gecerli_d;
  logic            mesgul_q, mesgul_d;
  logic            bitti_q, bitti_d;
`ifdef BUYRUK_HATA_SAYAC_EN
  logic [AW:0]     hata_q, hata_d;
  logic            gecersiz_q, gecersiz_d;
  logic            getir_gecersiz;
`endif

  logic [AW:0]     pc_art;
  logic [AW:0]     n_yeni;
  logic [AW-1:0]   oku_adres;
  logic [W-1:0]    oku_veri;
  logic [W-1:0]    getir;
  logic [W-1:0]    getir_buyruk;
  logic            yaz_izin;
  logic            ilerle;

  assign yaz_izin = yaz_en & ~mesgul_q;
  assign pc_art   = pc_q + 1'b1;
  assign n_yeni   = (program_boyu > Derinlik) ? Derinlik : program_boyu;
  // From idle the first fetch is address 0; afterwards it is always the next PC.
  assign oku_adres = (durum_q == StBosta) ? '0 : pc_art[AW-1:0];
  // A write landing in the same cycle as the fetch must be seen by that fetch.
  assign getir = (yaz_izin && (yaz_adres == oku_adres)) ? yaz_veri : oku_veri;

`ifdef BUYRUK_HATA_SAYAC_EN
  assign getir_gecersiz = gecersiz_op(op_al(32'(getir), UZUNLUK));
  assign getir_buyruk   = getir_gecersiz ? '0 : getir;
`else
  assign getir_buyruk   = getir;
`endif

  buyruk_bellek #(
    .Genislik (W),
    .Derinlik (DERINLIK)
  ) u_bellek (
    .clk_i       (clk),
    .yaz_en_i    (yaz_izin),
    .yaz_adres_i (yaz_adres),
    .yaz_veri_i  (yaz_veri),
    .oku_adres_i (oku_adres),
    .oku_veri_o  (oku_veri)
  );

  // Next-state and registered-output logic of the issue sequencer.
  always_comb begin
    durum_d         = durum_q;
    pc_d            = pc_q;
    n_d             = n_q;
    bekle_d         = bekle_q;
    buyruk_d        = buyruk_q;
    cikis_sonuc_d   = cikis_sonuc_q;
    cikis_adres_d   = cikis_adres_q;
    cikis_gecerli_d = cikis_gecerli_q;
    mesgul_d        = mesgul_q;
    bitti_d         = 1'b0;
    ilerle          = 1'b0;
`ifdef BUYRUK_HATA_SAYAC_EN
    hata_d          = hata_q;
    gecersiz_d      = gecersiz_q;
`endif

    unique case (durum_q)
      StBosta: begin
        if (basla) begin
`ifdef BUYRUK_HATA_SAYAC_EN
          hata_d = '0;
`endif
          if (n_yeni == '0) begin
            durum_d = StBitti;
            bitti_d = 1'b1;
          end else begin
            durum_d  = StGonder;
            pc_d     = '0;
            n_d      = n_yeni;
            mesgul_d = 1'b1;
            bekle_d  = '0;
            buyruk_d = getir_buyruk;
`ifdef BUYRUK_HATA_SAYAC_EN
            gecersiz_d = getir_gecersiz;
`endif
          end
        end
      end
      StGonder: begin
`ifdef BUYRUK_HATA_SAYAC_EN
        if (gecersiz_q) begin
          // Suppressed word: no result, count it and move on as after a handshake.
          hata_d = hata_q + 1'b1;
          ilerle = 1'b1;
        end else
`endif
        if (bekle_q == BekleSon) begin
          durum_d = StYakala;
        end else begin
          bekle_d = bekle_q + 1'b1;
        end
      end
      StYakala: begin
        cikis_sonuc_d   = bus.sonuc;
        cikis_adres_d   = pc_q[AW-1:0];
        cikis_gecerli_d = 1'b1;
        durum_d         = StCikis;
      end
      StCikis: begin
        if (cikis_gecerli_q && bus.cikis_hazir) begin
          cikis_gecerli_d = 1'b0;
          ilerle          = 1'b1;
        end
      end
      StBitti: begin
        durum_d = StBosta;
      end
      default: begin
        durum_d = StBosta;
      end
    endcase

    if (ilerle) begin
      pc_d = pc_art;
      if (pc_art == n_q) begin
        durum_d  = StBitti;
        bitti_d  = 1'b1;
        mesgul_d = 1'b0;
        buyruk_d = '0;
      end else begin
        durum_d  = StGonder;
        bekle_d  = '0;
        buyruk_d = getir_buyruk;
`ifdef BUYRUK_HATA_SAYAC_EN
        gecersiz_d = getir_gecersiz;
`endif
      end
    end
  end

  // All sequencer state and outputs; reset aborts a run without a bitti pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q         <= StBosta;
      pc_q            <= '0;
      n_q             <= '0;
      bekle_q         <= '0;
      buyruk_q        <= '0;
      cikis_sonuc_q   <= '0;
      cikis_adres_q   <= '0;
      cikis_gecerli_q <= 1'b0;
      mesgul_q        <= 1'b0;
      bitti_q         <= 1'b0;
`ifdef BUYRUK_HATA_SAYAC_EN
      hata_q          <= '0;
      gecersiz_q      <= 1'b0;
`endif
    end else begin
      durum_q         <= durum_d;
      pc_q            <= pc_d;
      n_q             <= n_d;
      bekle_q         <= bekle_d;
      buyruk_q        <= buyruk_d;
      cikis_sonuc_q   <= cikis_sonuc_d;
      cikis_adres_q   <= cikis_adres_d;
      cikis_gecerli_q <= cikis_gecerli_d;
      mesgul_q        <= mesgul_d;
      bitti_q         <= bitti_d;
`ifdef BUYRUK_HATA_SAYAC_EN
      hata_q          <= hata_d;
      gecersiz_q      <= gecersiz_d;
`endif
    end
  end

  assign bus.buyruk        = buyruk_q;
  assign bus.cikis_sonuc   = cikis_sonuc_q;
  assign bus.cikis_adres   = cikis_adres_q;
  assign bus.cikis_gecerli = cikis_gecerli_q;
  assign mesgul            = mesgul_q;
  assign bitti             = bitti_q;
`ifdef BUYRUK_HATA_SAYAC_EN
  assign hata_sayisi       = hata_q;
`endif

endmodule

// File: tb/tb_buyruk_sirala.sv
// Directed bench for buyruk_sirala with a reference ALU model (UZUNLUK=8, DERINLIK=16).
module tb_buyruk_sirala;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        yaz_en;
  logic [3:0]  yaz_adres;
  logic [10:0] yaz_veri;
  logic        basla;
  logic [4:0]  program_boyu;
  logic        mesgul;
  logic        bitti;
  logic [4:0]  hata;

  int hata_n = 0;
  int kontrol_n = 0;

  buyruk_sirala_if #(.UZUNLUK(8), .DERINLIK(16)) bus ();

  buyruk_sirala #(
    .UZUNLUK     (8),
    .DERINLIK    (16),
    .ALU_GECIKME (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .yaz_en       (yaz_en),
    .yaz_adres    (yaz_adres),
    .yaz_veri     (yaz_veri),
    .basla        (basla),
    .program_boyu (program_boyu),
    .bus          (bus),
    .mesgul       (mesgul),
`ifdef BUYRUK_HATA_SAYAC_EN
    .hata_sayisi  (hata),
`endif
    .bitti        (bitti)
  );

`ifndef BUYRUK_HATA_SAYAC_EN
  assign hata = '0;
`endif

  always #5 clk = ~clk;

  // Reference ALU: 4-bit operands, 9-bit result; illegal opcodes give a marker value.
  logic [8:0] alu_a, alu_b;
  always_comb begin
    alu_a = {5'b0, bus.buyruk[7:4]};
    alu_b = {5'b0, bus.buyruk[3:0]};
    case (bus.buyruk[10:8])
      3'b000:  bus.sonuc = alu_a + alu_b;
      3'b001:  bus.sonuc = alu_a - alu_b;
      3'b010:  bus.sonuc = alu_a & alu_b;
      3'b011:  bus.sonuc = alu_a | alu_b;
      3'b100:  bus.sonuc = alu_a ^ alu_b;
      default: bus.sonuc = 9'h1AA;
    endcase
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic kontrol(input string ad, input logic [31:0] gor, input logic [31:0] bek);
    kontrol_n++;
    assert (gor === bek) else begin
      hata_n++;
      $error("FAIL %s: observed=%0h expected=%0h", ad, gor, bek);
    end
  endtask

  task automatic yaz(input logic [3:0] a, input logic [10:0] v);
    yaz_en    = 1'b1;
    yaz_adres = a;
    yaz_veri  = v;
    tick();
    yaz_en    = 1'b0;
  endtask

  task automatic baslat(input logic [4:0] boyu);
    program_boyu = boyu;
    basla        = 1'b1;
    tick();
    basla        = 1'b0;
  endtask

  // Bounded wait for cikis_gecerli; the number of cycles waited is itself checked.
  task automatic sonuc_bekle(input string ad, input int bek_n);
    int n = 0;
    while (!bus.cikis_gecerli && n < 20) begin
      tick();
      n++;
    end
    kontrol({ad, "_gecikme"}, 32'(n), 32'(bek_n));
  endtask

  int         say;
  bit         bitti_gor;
  logic [8:0] rs [4];
  logic [3:0] ra [4];

  initial begin
    rst_n = 1'b0; yaz_en = 1'b0; yaz_adres = '0; yaz_veri = '0;
    basla = 1'b0; program_boyu = '0; bus.cikis_hazir = 1'b0;

    // Reset state
    #2;
    kontrol("rst_buyruk", 32'(bus.buyruk), 32'h0);
    kontrol("rst_gecerli", 32'(bus.cikis_gecerli), 32'h0);
    kontrol("rst_sonuc", 32'(bus.cikis_sonuc), 32'h0);
    kontrol("rst_mesgul", 32'(mesgul), 32'h0);
    kontrol("rst_bitti", 32'(bitti), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single add 5+3
    yaz(4'd0, 11'b000_0101_0011);
    bus.cikis_hazir = 1'b1;
    baslat(5'd1);
    kontrol("t1_buyruk", 32'(bus.buyruk), 32'h053);
    kontrol("t1_mesgul", 32'(mesgul), 32'h1);
    sonuc_bekle("t1", 2);
    kontrol("t1_sonuc", 32'(bus.cikis_sonuc), 32'h008);
    kontrol("t1_adres", 32'(bus.cikis_adres), 32'h0);
    tick();
    kontrol("t1_bitti", 32'(bitti), 32'h1);
    kontrol("t1_gecerli_dus", 32'(bus.cikis_gecerli), 32'h0);
    kontrol("t1_mesgul_dus", 32'(mesgul), 32'h0);
    kontrol("t1_buyruk_sifir", 32'(bus.buyruk), 32'h0);
    tick();
    kontrol("t1_bitti_tek", 32'(bitti), 32'h0);

    // 2: sub 3-5 then and F&3, in order
    yaz(4'd0, 11'b001_0011_0101);
    yaz(4'd1, 11'b010_1111_0011);
    baslat(5'd2);
    sonuc_bekle("t2a", 2);
    kontrol("t2_sonuc0", 32'(bus.cikis_sonuc), 32'h1FE);
    kontrol("t2_adres0", 32'(bus.cikis_adres), 32'h0);
    tick();
    sonuc_bekle("t2b", 2);
    kontrol("t2_sonuc1", 32'(bus.cikis_sonuc), 32'h003);
    kontrol("t2_adres1", 32'(bus.cikis_adres), 32'h1);
    tick();
    kontrol("t2_bitti", 32'(bitti), 32'h1);
    tick();

    // 3: back-pressure on the first result
    bus.cikis_hazir = 1'b0;
    baslat(5'd2);
    sonuc_bekle("t3a", 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      kontrol($sformatf("t3_gecerli%0d", i), 32'(bus.cikis_gecerli), 32'h1);
      kontrol($sformatf("t3_sonuc%0d", i), 32'(bus.cikis_sonuc), 32'h1FE);
      kontrol($sformatf("t3_adres%0d", i), 32'(bus.cikis_adres), 32'h0);
      kontrol($sformatf("t3_buyruk%0d", i), 32'(bus.buyruk), 32'h135);
    end
    bus.cikis_hazir = 1'b1;
    tick();
    kontrol("t3_gecerli_dus", 32'(bus.cikis_gecerli), 32'h0);
    kontrol("t3_buyruk2", 32'(bus.buyruk), 32'h2F3);
    sonuc_bekle("t3b", 2);
    kontrol("t3_sonuc1", 32'(bus.cikis_sonuc), 32'h003);
    kontrol("t3_adres1", 32'(bus.cikis_adres), 32'h1);
    tick();
    kontrol("t3_bitti", 32'(bitti), 32'h1);
    tick();

    // 4a: empty program
    baslat(5'd0);
    kontrol("t4_bos_bitti", 32'(bitti), 32'h1);
    kontrol("t4_bos_gecerli", 32'(bus.cikis_gecerli), 32'h0);
    kontrol("t4_bos_mesgul", 32'(mesgul), 32'h0);
    tick();
    kontrol("t4_bos_bitti_tek", 32'(bitti), 32'h0);

    // 4b: length 20 clamps to 16; mem[i] = i + 1
    for (int i = 0; i < 16; i++) begin
      yaz(4'(i), {3'b000, 4'(i), 4'd1});
    end
    baslat(5'd20);
    for (int i = 0; i < 16; i++) begin
      sonuc_bekle($sformatf("t4_%0d", i), 2);
      kontrol($sformatf("t4_adres%0d", i), 32'(bus.cikis_adres), 32'(i));
      kontrol($sformatf("t4_sonuc%0d", i), 32'(bus.cikis_sonuc), 32'(i + 1));
      tick();
    end
    kontrol("t4_bitti", 32'(bitti), 32'h1);
    kontrol("t4_gecerli_son", 32'(bus.cikis_gecerli), 32'h0);
    tick();

    // 5: reset during CIKIS, then a fresh run
    bus.cikis_hazir = 1'b0;
    baslat(5'd3);
    sonuc_bekle("t5a", 2);
    #2 rst_n = 1'b0;
    #1;
    kontrol("t5_gecerli", 32'(bus.cikis_gecerli), 32'h0);
    kontrol("t5_sonuc", 32'(bus.cikis_sonuc), 32'h0);
    kontrol("t5_buyruk", 32'(bus.buyruk), 32'h0);
    kontrol("t5_mesgul", 32'(mesgul), 32'h0);
    kontrol("t5_bitti", 32'(bitti), 32'h0);
    tick();
    rst_n = 1'b1;
    bus.cikis_hazir = 1'b1;
    baslat(5'd1);
    sonuc_bekle("t5b", 2);
    kontrol("t5_yeni_adres", 32'(bus.cikis_adres), 32'h0);
    kontrol("t5_yeni_sonuc", 32'(bus.cikis_sonuc), 32'h001);
    tick();
    kontrol("t5_yeni_bitti", 32'(bitti), 32'h1);
    tick();

    // Write and start in the same idle cycle: the write is fetched
    yaz_en = 1'b1; yaz_adres = 4'd0; yaz_veri = 11'h0FF;
    baslat(5'd1);
    yaz_en = 1'b0;
    kontrol("yb_buyruk", 32'(bus.buyruk), 32'h0FF);
    sonuc_bekle("yb", 2);
    kontrol("yb_sonuc", 32'(bus.cikis_sonuc), 32'h01E);
    tick();
    tick();

    // 6: {add 2+2, illegal 111, xor C^A}
    yaz(4'd0, 11'b000_0010_0010);
    yaz(4'd1, 11'b111_0001_0001);
    yaz(4'd2, 11'b100_1100_1010);
    baslat(5'd3);
    say = 0;
    bitti_gor = 1'b0;
    for (int c = 0; c < 40 && !bitti_gor; c++) begin
      if (bus.cikis_gecerli) begin
        if (say < 4) begin
          rs[say] = bus.cikis_sonuc;
          ra[say] = bus.cikis_adres;
        end
        say++;
      end
      if (bitti) bitti_gor = 1'b1;
      else tick();
    end
    kontrol("t6_bitti", 32'(bitti_gor), 32'h1);
    kontrol("t6_sonuc0", 32'(rs[0]), 32'h004);
    kontrol("t6_adres0", 32'(ra[0]), 32'h0);
`ifdef BUYRUK_HATA_SAYAC_EN
    kontrol("t6_say", 32'(say), 32'd2);
    kontrol("t6_sonuc1", 32'(rs[1]), 32'h006);
    kontrol("t6_adres1", 32'(ra[1]), 32'h2);
    kontrol("t6_hata", 32'(hata), 32'h1);
`else
    kontrol("t6_say", 32'(say), 32'd3);
    kontrol("t6_sonuc1", 32'(rs[1]), 32'h1AA);
    kontrol("t6_adres1", 32'(ra[1]), 32'h1);
    kontrol("t6_sonuc2", 32'(rs[2]), 32'h006);
    kontrol("t6_adres2", 32'(ra[2]), 32'h2);
    kontrol("t6_hata", 32'(hata), 32'h0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", hata_n, kontrol_n);
    $finish;
  end

endmodule
